// File: rtl/led_display_scheduler.sv
// led_display_scheduler: round-robin sharing of one 4-digit display among NSRC sources; LED_SCHED_FREEZE_EN adds a freeze input
module led_display_scheduler #(
  parameter int NSRC    = 4,
  parameter int SEL_W   = 2,
  parameter int DWELL   = 10000000,
  parameter int DWELL_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [16*NSRC-1:0]   src_data,
  input  logic [NSRC-1:0]      src_valid,
  input  logic                 auto_en,
  input  logic                 btn_next,
`ifdef LED_SCHED_FREEZE_EN
  input  logic                 freeze,
`endif
  output logic [15:0]          disp_value,
  output logic [SEL_W-1:0]     disp_sel,
  output logic                 disp_blank,
  output logic                 flush
);
  typedef enum logic [1:0] {IDLE, SHOW, SWITCH} state_t;
  localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);
  state_t state, nstate;
  logic [DWELL_W-1:0] cnt, ncnt;
  logic [15:0] nvalue, live;
  logic [SEL_W-1:0] nsel, lowest, rr;
  logic nblank, nflush, frz;
`ifdef LED_SCHED_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif
  assign live = src_data[{disp_sel, 4'b0} +: 16];
  always_comb begin
    lowest = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (src_valid[i]) lowest = SEL_W'(i);
  end
  // Scan downwards so the nearest valid index after disp_sel wins; k=NSRC lands back on disp_sel
  always_comb begin
    rr = disp_sel;
    for (int k = NSRC; k >= 1; k--)
      if (src_valid[disp_sel + SEL_W'(k)]) rr = disp_sel + SEL_W'(k);
  end
  always_comb begin
    nstate = state;
    nvalue = disp_value;
    nsel   = disp_sel;
    nblank = disp_blank;
    nflush = 1'b0;
    ncnt   = cnt;
    if (src_valid == '0) begin
      nstate = IDLE;
      nvalue = '0;
      nblank = 1'b1;
      ncnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          nstate = SHOW;
          nsel   = lowest;
          nblank = 1'b0;
          nflush = 1'b1;
          ncnt   = '0;
        end
        SHOW: begin
          nvalue = frz ? disp_value : live;
          if (!src_valid[disp_sel]) nstate = SWITCH;
          else if (!frz) begin
            ncnt   = (cnt == LAST) ? cnt : cnt + DWELL_W'(1);
            nstate = ((auto_en && cnt == LAST) || btn_next) ? SWITCH : SHOW;
          end
        end
        SWITCH: begin
          nstate = SHOW;
          nsel   = rr;
          nflush = rr != disp_sel;
          ncnt   = '0;
        end
        default: nstate = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      disp_value <= '0;
      disp_sel   <= '0;
      disp_blank <= 1'b1;
      flush      <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= nstate;
      disp_value <= nvalue;
      disp_sel   <= nsel;
      disp_blank <= nblank;
      flush      <= nflush;
      cnt        <= ncnt;
    end
  end
endmodule

// File: tb/tb_led_display_scheduler.sv
// tb_led_display_scheduler: directed stimulus with a cycle-level behavioural model and literal checks
module tb_led_display_scheduler;
  localparam int NSRC = 4, SEL_W = 2, DWELL = 8, DWELL_W = 4;
  logic clk = 0, rst = 1;
  logic [16*NSRC-1:0] src_data;
  logic [NSRC-1:0] src_valid;
  logic auto_en, btn_next, freeze;
  logic [15:0] disp_value;
  logic [SEL_W-1:0] disp_sel;
  logic disp_blank, flush;
  int checks = 0, errors = 0;
  bit check_on = 0;

  led_display_scheduler #(.NSRC(NSRC), .SEL_W(SEL_W), .DWELL(DWELL), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .auto_en(auto_en), .btn_next(btn_next),
`ifdef LED_SCHED_FREEZE_EN
    .freeze(freeze),
`endif
    .disp_value(disp_value), .disp_sel(disp_sel), .disp_blank(disp_blank), .flush(flush));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: phase 0 = blank, 1 = showing, 2 = choosing the next source
  int m_phase, m_sel, m_age, m_val;
  bit m_blank, m_flush;
  always @(posedge clk) begin
    bit frz;
    int nxt;
`ifdef LED_SCHED_FREEZE_EN
    frz = freeze;
`else
    frz = 0;
`endif
    if (rst) begin
      m_phase = 0; m_sel = 0; m_age = 0; m_val = 0; m_blank = 1; m_flush = 0;
    end else begin
      m_flush = 0;
      if (src_valid == 0) begin
        m_phase = 0; m_val = 0; m_blank = 1; m_age = 0;
      end else if (m_phase == 0) begin
        for (int i = 0; i < NSRC; i++)
          if (src_valid[i]) begin m_sel = i; break; end
        m_blank = 0; m_flush = 1; m_age = 0; m_phase = 1;
      end else if (m_phase == 1) begin
        if (!frz) m_val = int'(src_data[16*m_sel +: 16]);
        if (!src_valid[m_sel]) m_phase = 2;
        else if (!frz && ((auto_en && m_age >= DWELL - 1) || btn_next)) m_phase = 2;
        else if (!frz) m_age++;
      end else begin
        nxt = m_sel;
        for (int k = 1; k <= NSRC; k++)
          if (src_valid[(m_sel + k) % NSRC]) begin nxt = (m_sel + k) % NSRC; break; end
        m_flush = nxt != m_sel;
        m_sel = nxt; m_age = 0; m_phase = 1;
      end
    end
  end

  always @(negedge clk) if (check_on) begin
    chk("value", disp_value, m_val);
    chk("sel", disp_sel, m_sel);
    chk("blank", disp_blank, m_blank);
    chk("flush", flush, m_flush);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    src_data = {16'h3333, 16'h2222, 16'h1111, 16'h1234};
    src_valid = 0; auto_en = 0; btn_next = 0; freeze = 0;
    tick(); check_on = 1;
    tick(); rst = 0;
    tick(3);
    chk("lit_reset_blank", disp_blank, 1);
    chk("lit_reset_value", disp_value, 0);
    chk("lit_reset_flush", flush, 0);
    src_valid = 4'b0101; auto_en = 1;
    tick();
    chk("lit_unblank_sel", disp_sel, 0);
    chk("lit_unblank_flush", flush, 1);
    chk("lit_unblank_blank", disp_blank, 0);
    tick();
    chk("lit_first_value", disp_value, 16'h1234);
    chk("lit_first_flush", flush, 0);
    tick(8);
    chk("lit_auto1_sel", disp_sel, 2);
    chk("lit_auto1_flush", flush, 1);
    tick(9);
    chk("lit_auto2_sel", disp_sel, 0);
    tick(9);
    chk("lit_auto3_sel", disp_sel, 2);
    tick();
    chk("lit_auto3_value", disp_value, 16'h2222);
    auto_en = 0; src_valid = 4'b1011;
    tick(2);
    chk("lit_forced_sel", disp_sel, 3);
    chk("lit_forced_flush", flush, 1);
    btn_next = 1;
    tick(2);
    btn_next = 0;
    chk("lit_btn_sel", disp_sel, 0);
    chk("lit_btn_flush", flush, 1);
    tick(10);
    chk("lit_manual_hold", disp_sel, 0);
    auto_en = 1; btn_next = 1;
    tick();
    auto_en = 0; btn_next = 0;
    tick();
    chk("lit_simul_sel", disp_sel, 1);
    tick(3);
    chk("lit_simul_once", disp_sel, 1);
    auto_en = 1; src_valid = 4'b0100;
    tick(2);
    chk("lit_sole_sel", disp_sel, 2);
    tick(9);
    chk("lit_sole_stay", disp_sel, 2);
    chk("lit_sole_noflush", flush, 0);
    tick(3);
    src_valid = 0;
    tick();
    chk("lit_idle_blank", disp_blank, 1);
    chk("lit_idle_value", disp_value, 0);
    src_valid = 4'b1000;
    tick(3);
    chk("lit_pre_rst_sel", disp_sel, 3);
    rst = 1;
    tick();
    chk("lit_rst_sel", disp_sel, 0);
    chk("lit_rst_blank", disp_blank, 1);
    chk("lit_rst_flush", flush, 0);
    rst = 0;
    tick();
    chk("lit_rerun_flush", flush, 1);
    tick();
    chk("lit_rerun_value", disp_value, 16'h3333);
`ifdef LED_SCHED_FREEZE_EN
    freeze = 1;
    src_data[48 +: 16] = 16'habcd;
    tick(3);
    chk("lit_freeze_hold", disp_value, 16'h3333);
    freeze = 0;
    tick();
    chk("lit_freeze_release", disp_value, 16'habcd);
`else
    src_data[48 +: 16] = 16'habcd;
    tick();
    chk("lit_live_track", disp_value, 16'habcd);
`endif
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
